// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle RV32 core.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback over a single shared memory port. It stalls on mem_ready in the
// request states. All outputs are combinational from the state register and
// the decode inputs.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   opcode/func3/func7_5 instruction fields from the instruction register
//   zero                ALUResult == 0 from the datapath
//   mem_ready           memory completed the current request this cycle
//   mem_req/AdrSrc/MemWrite                memory port control
//   IRWrite/PCWrite/RegWrite               architectural write strobes
//   ALUSrcA/ALUSrcB/ResultSrc/ALUControl   datapath selects and ALU operation
//   instr_done          one-cycle pulse in the final cycle of an instruction
//   illegal             high while trapped
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t state, state_nxt;

  logic [2:0] alu_dec;
  logic       alu_bad;
  logic       req_s, mw_s, irw_s, pcw_s, rw_s, done_s;

  // ALU operation decode from func3 (sub only for R-type with func7_5)
  always_comb begin
    alu_dec = 3'b000;
    alu_bad = 1'b0;
    case (func3)
      3'b000:  alu_dec = (opcode == OP_R && func7_5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b100:  alu_dec = 3'b110;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      3'b101:  alu_dec = 3'b111;
      default: alu_bad = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // Next state and per-state outputs
  always_comb begin
    state_nxt  = state;
    req_s      = 1'b0;
    AdrSrc     = 1'b0;
    mw_s       = 1'b0;
    irw_s      = 1'b0;
    pcw_s      = 1'b0;
    rw_s       = 1'b0;
    done_s     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        req_s     = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          irw_s     = 1'b1;
          pcw_s     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target computed early into ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I, OP_LUI:      state_nxt = S_EXECI;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_s  = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_s      = 1'b1;
        done_s    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        req_s  = 1'b1;
        AdrSrc = 1'b1;
        mw_s   = 1'b1;
        if (mem_ready) begin
          done_s    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_nxt  = alu_bad ? S_TRAP : S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // lui passes the immediate straight through; its func3 bits are data
        if (opcode == OP_LUI) begin
          ALUControl = 3'b100;
          state_nxt  = S_ALUWB;
        end else begin
          ALUControl = alu_dec;
          state_nxt  = alu_bad ? S_TRAP : S_ALUWB;
        end
      end
      S_ALUWB: begin
        rw_s      = 1'b1;
        done_s    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        case (func3)
          3'b000: begin
            pcw_s     = zero;
            done_s    = 1'b1;
            state_nxt = S_FETCH;
          end
          3'b001: begin
            pcw_s     = ~zero;
            done_s    = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_TRAP;
        endcase
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcw_s     = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Strobes are suppressed while reset is asserted
  assign mem_req    = req_s  & rst;
  assign MemWrite   = mw_s   & rst;
  assign IRWrite    = irw_s  & rst;
  assign PCWrite    = pcw_s  & rst;
  assign RegWrite   = rw_s   & rst;
  assign instr_done = done_s & rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: randomized instruction stream checked every
// cycle against a step-list model, plus directed latency/value literals.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic [2:0] alu;
    logic       done;
    logic       ill;
  } outs_t;

  // One model step: outputs, extra outputs once mem_ready accepts, stall flag
  typedef struct {
    outs_t base;
    outs_t extra;
    bit    wait_rdy;
    bit    sticky;
  } step_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic       z;
  } instr_t;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t  dut_vec;
  outs_t  exp_vec;
  bit     chk_en = 1'b0;
  int     checks = 0;
  int     errors = 0;
  int     cyc_n  = 0;
  step_t  q[$];
  instr_t dir_q[$];

  assign dut_vec = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUControl, instr_done, illegal};

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b", cyc_n, dut_vec, exp_vec);
      end
    end
  end

  function automatic outs_t sel(input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] r, input logic [2:0] alu);
    outs_t o;
    o = '0;
    o.src_a = a; o.src_b = b; o.res_src = r; o.alu = alu;
    return o;
  endfunction

  function automatic void push(input outs_t b, input outs_t e, input bit w, input bit s);
    step_t st;
    st.base = b; st.extra = e; st.wait_rdy = w; st.sticky = s;
    q.push_back(st);
  endfunction

  function automatic void push_trap();
    outs_t b;
    b = '0; b.ill = 1'b1;
    push(b, '0, 1'b0, 1'b1);
  endfunction

  function automatic void push_aluwb();
    outs_t b;
    b = sel(2'b00, 2'b00, 2'b00, 3'b000); b.reg_write = 1'b1; b.done = 1'b1;
    push(b, '0, 1'b0, 1'b0);
  endfunction

  // Reference ALU decode table
  function automatic logic [2:0] ref_alu(input instr_t i, output bit bad);
    bad = 1'b0;
    if (i.op == OP_LUI) return 3'b100;
    case (i.f3)
      3'b000:  return (i.op == OP_R && i.f75) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b110;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      3'b101:  return 3'b111;
      default: begin bad = 1'b1; return 3'b000; end
    endcase
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction
  function automatic void build(input instr_t i);
    outs_t b, e;
    bit bad;
    logic [2:0] alu;
    q.delete();
    b = sel(2'b00, 2'b10, 2'b10, 3'b000); b.mem_req = 1'b1;
    e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(b, e, 1'b1, 1'b0);
    push(sel(2'b01, 2'b01, 2'b00, 3'b000), '0, 1'b0, 1'b0);
    case (i.op)
      OP_LOAD: begin
        push(sel(2'b10, 2'b01, 2'b00, 3'b000), '0, 1'b0, 1'b0);
        b = '0; b.mem_req = 1'b1; b.adr_src = 1'b1;
        push(b, '0, 1'b1, 1'b0);
        b = sel(2'b00, 2'b00, 2'b01, 3'b000); b.reg_write = 1'b1; b.done = 1'b1;
        push(b, '0, 1'b0, 1'b0);
      end
      OP_STORE: begin
        push(sel(2'b10, 2'b01, 2'b00, 3'b000), '0, 1'b0, 1'b0);
        b = '0; b.mem_req = 1'b1; b.adr_src = 1'b1; b.mem_write = 1'b1;
        e = '0; e.done = 1'b1;
        push(b, e, 1'b1, 1'b0);
      end
      OP_R, OP_I, OP_LUI: begin
        alu = ref_alu(i, bad);
        push(sel(2'b10, (i.op == OP_R) ? 2'b00 : 2'b01, 2'b00, alu), '0, 1'b0, 1'b0);
        if (bad) push_trap();
        else push_aluwb();
      end
      OP_BR: begin
        b = sel(2'b10, 2'b00, 2'b00, 3'b001);
        if (i.f3 == 3'b000 || i.f3 == 3'b001) begin
          b.pc_write = (i.f3 == 3'b000) ? i.z : !i.z;
          b.done = 1'b1;
          push(b, '0, 1'b0, 1'b0);
        end else begin
          push(b, '0, 1'b0, 1'b0);
          push_trap();
        end
      end
      OP_JAL: begin
        b = sel(2'b01, 2'b10, 2'b00, 3'b000); b.pc_write = 1'b1;
        push(b, '0, 1'b0, 1'b0);
        push_aluwb();
      end
      default: push_trap();
    endcase
  endfunction

  function automatic instr_t mk_i(input logic [6:0] op, input logic [2:0] f3,
                                  input logic f75, input logic z);
    instr_t i;
    i.op = op; i.f3 = f3; i.f75 = f75; i.z = z;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [2:0] lf [6];
    logic [6:0] bad_ops [3];
    lf = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    bad_ops = '{7'b0000000, 7'b1111111, 7'b1100111};
    i.f3  = 3'($urandom_range(0, 7));
    i.f75 = 1'($urandom_range(0, 1));
    i.z   = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       i.op = OP_LOAD;
      1:       i.op = OP_STORE;
      2, 8:    i.op = OP_R;
      3:       i.op = OP_I;
      4:       begin i.op = OP_LUI; i.f3 = lf[$urandom_range(0, 5)]; end
      5, 9:    begin
                 i.op = OP_BR;
                 if ($urandom_range(0, 4) != 0) i.f3 = 3'($urandom_range(0, 1));
               end
      6:       i.op = OP_JAL;
      default: i.op = bad_ops[$urandom_range(0, 2)];
    endcase
    return i;
  endfunction

  // One clock cycle: drive inputs after the edge, derive the expected outputs
  task automatic cyc(input bit rdy, input bit rst_v);
    step_t st;
    instr_t ni;
    @(posedge clk); #1;
    rst = rst_v;
    mem_ready = rdy;
    if (!rst_v) begin
      q.delete();
      exp_vec = sel(2'b00, 2'b10, 2'b10, 3'b000);
    end else begin
      if (q.size() == 0) begin
        if (dir_q.size() > 0) ni = dir_q.pop_front();
        else ni = rand_instr();
        opcode = ni.op; func3 = ni.f3; func7_5 = ni.f75; zero = ni.z;
        build(ni);
      end
      st = q[0];
      if (st.sticky || (st.wait_rdy && !rdy)) exp_vec = st.base;
      else begin
        exp_vec = st.base | st.extra;
        q.delete(0);
      end
    end
    chk_en = 1'b1;
    cyc_n++;
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Run one instruction; report cycles to instr_done and a few observations
  task automatic run_lat(input instr_t ins, input logic [31:0] nrdy, output int lat,
                         output int pcw, output logic [2:0] alu3, output logic [2:0] last);
    dir_q.push_back(ins);
    lat = 0; pcw = 0; alu3 = 3'b000; last = 3'b000;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      cyc(!nrdy[c], 1'b1);
      if (PCWrite) pcw++;
      if (c == 3) alu3 = ALUControl;
      if (instr_done) begin
        lat = c;
        last = {RegWrite, ResultSrc};
      end
    end
  endtask

  initial begin
    int lat, pcw, strobes, trap_cnt, rst_left;
    logic [2:0] alu3, last;
    rst = 1'b1; mem_ready = 1'b0; opcode = 7'd0; func3 = 3'd0; func7_5 = 1'b0; zero = 1'b0;
    #2 rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0);
      chk("reset_strobes", 32'({mem_req, PCWrite, IRWrite}), 32'd0);
    end
    dir_q.push_back(mk_i(OP_R, 3'b000, 1'b0, 1'b0));
    cyc(1'b1, 1'b1);
    chk("post_reset_fetch", 32'({IRWrite, PCWrite}), 32'd3);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1);

    run_lat(mk_i(OP_R, 3'b000, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("add_lat", 32'(lat), 32'd4); chk("add_alu", 32'(alu3), 32'd0);
    chk("add_last", 32'(last), 32'b100);
    run_lat(mk_i(OP_R, 3'b000, 1'b1, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("sub_lat", 32'(lat), 32'd4); chk("sub_alu", 32'(alu3), 32'b001);
    run_lat(mk_i(OP_R, 3'b100, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("xor_alu", 32'(alu3), 32'b110);
    run_lat(mk_i(OP_LOAD, 3'b010, 1'b0, 1'b0), 32'h30, lat, pcw, alu3, last);
    chk("lw_stall_lat", 32'(lat), 32'd7); chk("lw_pcw", 32'(pcw), 32'd1);
    chk("lw_last", 32'(last), 32'b101);
    run_lat(mk_i(OP_LOAD, 3'b010, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("lw_lat", 32'(lat), 32'd5);
    run_lat(mk_i(OP_STORE, 3'b010, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("sw_lat", 32'(lat), 32'd4);
    run_lat(mk_i(OP_STORE, 3'b010, 1'b0, 1'b0), 32'h10, lat, pcw, alu3, last);
    chk("sw_stall_lat", 32'(lat), 32'd5);
    run_lat(mk_i(OP_I, 3'b000, 1'b1, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("addi_lat", 32'(lat), 32'd4); chk("addi_alu", 32'(alu3), 32'd0);
    run_lat(mk_i(OP_LUI, 3'b000, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("lui_lat", 32'(lat), 32'd4); chk("lui_alu", 32'(alu3), 32'b100);
    run_lat(mk_i(OP_JAL, 3'b000, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("jal_lat", 32'(lat), 32'd4); chk("jal_pcw", 32'(pcw), 32'd2);
    chk("jal_last", 32'(last), 32'b100);
    run_lat(mk_i(OP_BR, 3'b000, 1'b0, 1'b1), 32'd0, lat, pcw, alu3, last);
    chk("beq_taken_lat", 32'(lat), 32'd3); chk("beq_taken_pcw", 32'(pcw), 32'd2);
    run_lat(mk_i(OP_BR, 3'b001, 1'b0, 1'b1), 32'd0, lat, pcw, alu3, last);
    chk("bne_nt_lat", 32'(lat), 32'd3); chk("bne_nt_pcw", 32'(pcw), 32'd1);
    run_lat(mk_i(OP_BR, 3'b001, 1'b0, 1'b0), 32'd0, lat, pcw, alu3, last);
    chk("bne_t_pcw", 32'(pcw), 32'd2); chk("bne_t_res", 32'(ResultSrc), 32'd0);

    dir_q.push_back(mk_i(7'b0000000, 3'b000, 1'b0, 1'b0));
    strobes = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc(1'b1, 1'b1);
      if (c >= 3 && (mem_req | MemWrite | IRWrite | PCWrite | RegWrite | instr_done)) strobes++;
    end
    chk("trap_strobes", 32'(strobes), 32'd0);
    chk("trap_illegal", 32'(illegal), 32'd1);
    cyc(1'b1, 1'b0);
    chk("trap_reset_illegal", 32'(illegal), 32'd0);

    trap_cnt = 0;
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rdy;
      rdy = ($urandom_range(0, 9) < 7);
      if (rst_left == 0 && (trap_cnt >= 10 || $urandom_range(0, 79) == 0))
        rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        cyc(rdy, 1'b0);
        rst_left--;
      end else begin
        cyc(rdy, 1'b1);
      end
      trap_cnt = exp_vec.ill ? trap_cnt + 1 : 0;
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
